// File: rtl/stopwatch_time_counter.sv
// 1 Hz time-base plus mm:ss counter driven by the stopwatch control FSM's count_enable.
// Optional lap capture registers are built when LAP_CAPTURE_EN is defined.
module stopwatch_time_counter #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned MAX_MIN  = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       count_enable,
    input  logic       clear,
    output logic [5:0] seconds,
    output logic [6:0] minutes,
    output logic       sec_tick,
    output logic       rollover
`ifdef LAP_CAPTURE_EN
    ,
    input  logic       lap,
    output logic [5:0] lap_seconds,
    output logic [6:0] lap_minutes,
    output logic       lap_valid
`endif
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]      MIN_LAST = 7'(MAX_MIN);
    localparam logic [5:0]      SEC_LAST = 6'd59;

    logic [PRE_W-1:0] prescaler;
    logic             tick_now;
    logic [5:0]       sec_next;
    logic [6:0]       min_next;
    logic             wrap_next;

    assign tick_now = (prescaler == PRE_LAST);

    // Next mm:ss value for a one-second step; out-of-range values fall into the wrap branches.
    always_comb begin
        sec_next  = seconds;
        min_next  = minutes;
        wrap_next = 1'b0;
        if (seconds >= SEC_LAST) begin
            sec_next = 6'd0;
            if (minutes >= MIN_LAST) begin
                min_next  = 7'd0;
                wrap_next = 1'b1;
            end else begin
                min_next = minutes + 7'd1;
            end
        end else begin
            sec_next = seconds + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            seconds   <= 6'd0;
            minutes   <= 7'd0;
            sec_tick  <= 1'b0;
            rollover  <= 1'b0;
        end else if (clear) begin
            prescaler <= '0;
            seconds   <= 6'd0;
            minutes   <= 7'd0;
            sec_tick  <= 1'b0;
            rollover  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            rollover <= 1'b0;
            // A paused count keeps the prescaler so the partial second survives.
            if (count_enable) begin
                if (tick_now) begin
                    prescaler <= '0;
                    seconds   <= sec_next;
                    minutes   <= min_next;
                    sec_tick  <= 1'b1;
                    rollover  <= wrap_next;
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end
        end
    end

`ifdef LAP_CAPTURE_EN
    // Lap snapshot takes the pre-edge time, independent of count_enable.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            lap_seconds <= 6'd0;
            lap_minutes <= 7'd0;
            lap_valid   <= 1'b0;
        end else if (lap) begin
            lap_seconds <= seconds;
            lap_minutes <= minutes;
            lap_valid   <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter: elapsed-count reference model, directed and random phases.
module tb_stopwatch_time_counter;

    localparam int TD = 4;
    localparam int MM = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       count_enable = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [5:0] seconds;
    logic [6:0] minutes;
    logic       sec_tick;
    logic       rollover;
`ifdef LAP_CAPTURE_EN
    logic [5:0] lap_seconds;
    logic [6:0] lap_minutes;
    logic       lap_valid;
`endif

    stopwatch_time_counter #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .count_enable(count_enable),
        .clear(clear),
        .seconds(seconds),
        .minutes(minutes),
        .sec_tick(sec_tick),
        .rollover(rollover)
`ifdef LAP_CAPTURE_EN
        ,
        .lap(lap),
        .lap_seconds(lap_seconds),
        .lap_minutes(lap_minutes),
        .lap_valid(lap_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sec;
        int min;
        bit tick;
        bit roll;
        int lsec;
        int lmin;
        bit lvld;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   started = 0;
    bit   done = 0;

    // Reference state: enabled edges elapsed since the last clear/reset.
    longint ticks = 0;
    bit m_tick = 0, m_roll = 0;
    int m_lsec = 0, m_lmin = 0;
    bit m_lvld = 0;

    function automatic int m_sec();
        return int'((ticks / TD) % 60);
    endfunction

    function automatic int m_min();
        return int'((ticks / TD / 60) % (MM + 1));
    endfunction

    task automatic step(input bit r, input bit e, input bit c, input bit l);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        count_enable = e;
        clear = c;
        lap = l;
        m_tick = 0;
        m_roll = 0;
        if (!r || c) begin
            ticks = 0;
            m_lsec = 0;
            m_lmin = 0;
            m_lvld = 0;
        end else begin
            if (l) begin
                m_lsec = m_sec();
                m_lmin = m_min();
                m_lvld = 1;
            end
            if (e) begin
                ticks++;
                m_tick = (ticks % TD) == 0;
                m_roll = m_tick && ((ticks / TD) % (60 * (MM + 1))) == 0;
            end
        end
        x.sec = m_sec();
        x.min = m_min();
        x.tick = m_tick;
        x.roll = m_roll;
        x.lsec = m_lsec;
        x.lmin = m_lmin;
        x.lvld = m_lvld;
        exp_q.push_back(x);
        started = 1;
    endtask

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: every clock edge presents a new output set.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (started && !done) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 0, 1);
                end else begin
                    x = exp_q.pop_front();
                    check("seconds", int'(seconds), x.sec);
                    check("minutes", int'(minutes), x.min);
                    check("sec_tick", int'(sec_tick), int'(x.tick));
                    check("rollover", int'(rollover), int'(x.roll));
`ifdef LAP_CAPTURE_EN
                    check("lap_seconds", int'(lap_seconds), x.lsec);
                    check("lap_minutes", int'(lap_minutes), x.lmin);
                    check("lap_valid", int'(lap_valid), int'(x.lvld));
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // Reset held with enable high
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        // Basic count: seconds 1,2,3 on edges 4,8,12
        repeat (12) step(1, 1, 0, 0);
        // Pause / resume keeps the partial second
        repeat (2) step(1, 1, 0, 0);
        repeat (10) step(1, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0);
        // Clear on the tick edge at 00:05
        guard = 0;
        while (!(m_sec() == 5 && (ticks % TD) == TD - 1) && guard < 200) begin
            step(1, 1, 0, 0);
            guard++;
        end
        check("reach_0005", guard < 200 ? 1 : 0, 1);
        step(1, 1, 1, 0);
        repeat (2) step(1, 1, 1, 0);
        repeat (TD + 1) step(1, 1, 0, 0);
        // Lap at 00:03, run on to 00:06, then clear
        step(1, 0, 1, 0);
        repeat (3 * TD) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        repeat (3 * TD) step(1, 1, 0, 0);
        step(1, 0, 1, 1);
        // Continuous run through the minute carry and the MAX_MIN:59 wrap
        repeat (2 * 60 * (MM + 1) * TD + 20) step(1, 1, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, e, c, l;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 149) == 0);
            l = ($urandom_range(0, 29) == 0);
            step(r, e, c, l);
        end
        @(posedge clk);
        #5;
        done = 1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
